// File: rtl/gp0_axil_fifo_bridge.sv
// AXI4-Lite slave bridging a PS-side register window to two PL stream FIFOs.
// CSR scratch, STATUS, PUSH (into out FIFO) and POP (from in FIFO) registers.
module gp0_axil_fifo_bridge #(
  parameter int C_GP0_AXI_ADDR_WIDTH = 10,
  parameter int C_GP0_AXI_DATA_WIDTH = 32,
  parameter int fifo_els_p           = 4
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [C_GP0_AXI_ADDR_WIDTH-1:0]   gp0_axi_awaddr,
  input  logic [2:0]                        gp0_axi_awprot,
  input  logic                              gp0_axi_awvalid,
  output logic                              gp0_axi_awready,
  input  logic [C_GP0_AXI_DATA_WIDTH-1:0]   gp0_axi_wdata,
  input  logic [C_GP0_AXI_DATA_WIDTH/8-1:0] gp0_axi_wstrb,
  input  logic                              gp0_axi_wvalid,
  output logic                              gp0_axi_wready,
  output logic [1:0]                        gp0_axi_bresp,
  output logic                              gp0_axi_bvalid,
  input  logic                              gp0_axi_bready,
  input  logic [C_GP0_AXI_ADDR_WIDTH-1:0]   gp0_axi_araddr,
  input  logic [2:0]                        gp0_axi_arprot,
  input  logic                              gp0_axi_arvalid,
  output logic                              gp0_axi_arready,
  output logic [C_GP0_AXI_DATA_WIDTH-1:0]   gp0_axi_rdata,
  output logic [1:0]                        gp0_axi_rresp,
  output logic                              gp0_axi_rvalid,
  input  logic                              gp0_axi_rready,
  output logic                              out_v_o,
  output logic [C_GP0_AXI_DATA_WIDTH-1:0]   out_data_o,
  input  logic                              out_ready_i,
  input  logic                              in_v_i,
  input  logic [C_GP0_AXI_DATA_WIDTH-1:0]   in_data_i,
  output logic                              in_ready_o
);

  localparam int DATA_W = C_GP0_AXI_DATA_WIDTH;
  localparam int ADDR_W = C_GP0_AXI_ADDR_WIDTH;
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(fifo_els_p);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(fifo_els_p);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  localparam logic [1:0] A_CSR = 2'd0, A_STATUS = 2'd1, A_PUSH = 2'd2, A_POP = 2'd3;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t r_wstate, w_wstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;

  logic [DATA_W-1:0] r_csr, r_rdata;
  logic              r_ovf, r_udf;
  logic [1:0]        r_bresp, r_rresp;
  logic [DATA_W-1:0] r_out_mem [fifo_els_p];
  logic [DATA_W-1:0] r_in_mem  [fifo_els_p];
  logic [PTR_W-1:0]  r_out_wp, r_out_rp, r_in_wp, r_in_rp;
  logic [CNT_W-1:0]  r_out_cnt, r_in_cnt;

  logic              w_wr_hs, w_rd_hs, w_aw_map, w_ar_map;
  logic [1:0]        w_aw_sel, w_ar_sel;
  logic              w_out_full, w_in_empty;
  logic              w_out_enq, w_out_deq, w_in_enq, w_in_deq;
  logic              w_ovf_set, w_udf_set, w_csr_wr, w_stat_rd;
  logic [DATA_W-1:0] w_status, w_rdata_nxt;
  logic [1:0]        w_rresp_nxt;
  logic              w_unused_ok;

  assign w_unused_ok = &{1'b0, gp0_axi_awprot, gp0_axi_arprot,
                         gp0_axi_awaddr[1:0], gp0_axi_araddr[1:0]};

  assign w_aw_map   = (gp0_axi_awaddr[ADDR_W-1:4] == '0);
  assign w_ar_map   = (gp0_axi_araddr[ADDR_W-1:4] == '0);
  assign w_aw_sel   = gp0_axi_awaddr[3:2];
  assign w_ar_sel   = gp0_axi_araddr[3:2];
  assign w_out_full = (r_out_cnt == FULL_CNT);
  assign w_in_empty = (r_in_cnt == '0);

  always_comb begin
    w_wstate_nxt   = r_wstate;
    w_wr_hs        = 1'b0;
    gp0_axi_bvalid = 1'b0;
    case (r_wstate)
      W_IDLE: if (gp0_axi_awvalid && gp0_axi_wvalid && !areset) begin
        w_wr_hs      = 1'b1;
        w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        gp0_axi_bvalid = 1'b1;
        if (gp0_axi_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt    = r_rstate;
    w_rd_hs         = 1'b0;
    gp0_axi_arready = 1'b0;
    gp0_axi_rvalid  = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        gp0_axi_arready = !areset;
        if (gp0_axi_arvalid && !areset) begin
          w_rd_hs      = 1'b1;
          w_rstate_nxt = R_RESP;
        end
      end
      R_RESP: begin
        gp0_axi_rvalid = 1'b1;
        if (gp0_axi_rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign gp0_axi_awready = w_wr_hs;
  assign gp0_axi_wready  = w_wr_hs;

  // Full/empty decisions use the registered counts, never same-cycle traffic.
  assign w_out_enq = w_wr_hs && w_aw_map && (w_aw_sel == A_PUSH) && !w_out_full;
  assign w_ovf_set = w_wr_hs && w_aw_map && (w_aw_sel == A_PUSH) && w_out_full;
  assign w_csr_wr  = w_wr_hs && w_aw_map && (w_aw_sel == A_CSR);
  assign w_out_deq = out_v_o && out_ready_i;
  assign w_in_enq  = in_v_i && in_ready_o;
  assign w_in_deq  = w_rd_hs && w_ar_map && (w_ar_sel == A_POP) && !w_in_empty;
  assign w_udf_set = w_rd_hs && w_ar_map && (w_ar_sel == A_POP) && w_in_empty;
  assign w_stat_rd = w_rd_hs && w_ar_map && (w_ar_sel == A_STATUS);

  always_comb begin
    w_status        = '0;
    w_status[7:0]   = 8'(r_out_cnt);
    w_status[15:8]  = 8'(r_in_cnt);
    w_status[16]    = r_ovf;
    w_status[17]    = r_udf;
  end

  always_comb begin
    w_rdata_nxt = '0;
    w_rresp_nxt = RESP_OKAY;
    if (w_ar_map) begin
      case (w_ar_sel)
        A_CSR:    w_rdata_nxt = r_csr;
        A_STATUS: w_rdata_nxt = w_status;
        A_POP: begin
          if (w_in_empty) w_rresp_nxt = RESP_SLVERR;
          else            w_rdata_nxt = r_in_mem[r_in_rp];
        end
        default: w_rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wstate  <= W_IDLE;
      r_rstate  <= R_IDLE;
      r_bresp   <= RESP_OKAY;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_csr     <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_in_wp   <= '0;
      r_in_rp   <= '0;
      r_out_cnt <= '0;
      r_in_cnt  <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      if (w_wr_hs) r_bresp <= w_ovf_set ? RESP_SLVERR : RESP_OKAY;
      if (w_rd_hs) begin
        r_rdata <= w_rdata_nxt;
        r_rresp <= w_rresp_nxt;
      end
      if (w_csr_wr) begin
        for (int b = 0; b < STRB_W; b++)
          if (gp0_axi_wstrb[b]) r_csr[8*b +: 8] <= gp0_axi_wdata[8*b +: 8];
      end
      // A sticky flag raised in the same cycle as a STATUS read survives the clear.
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_stat_rd) r_ovf <= 1'b0;
      if (w_udf_set)      r_udf <= 1'b1;
      else if (w_stat_rd) r_udf <= 1'b0;
      if (w_out_enq) r_out_wp <= r_out_wp + PTR_W'(1);
      if (w_out_deq) r_out_rp <= r_out_rp + PTR_W'(1);
      if (w_in_enq)  r_in_wp  <= r_in_wp + PTR_W'(1);
      if (w_in_deq)  r_in_rp  <= r_in_rp + PTR_W'(1);
      r_out_cnt <= r_out_cnt + CNT_W'(w_out_enq) - CNT_W'(w_out_deq);
      r_in_cnt  <= r_in_cnt + CNT_W'(w_in_enq) - CNT_W'(w_in_deq);
    end
  end

  always_ff @(posedge aclk) begin
    if (w_out_enq) r_out_mem[r_out_wp] <= gp0_axi_wdata;
    if (w_in_enq)  r_in_mem[r_in_wp]   <= in_data_i;
  end

  assign gp0_axi_bresp = r_bresp;
  assign gp0_axi_rresp = r_rresp;
  assign gp0_axi_rdata = r_rdata;
  assign out_v_o       = (r_out_cnt != '0);
  assign out_data_o    = r_out_mem[r_out_rp];
  assign in_ready_o    = !areset && (r_in_cnt != FULL_CNT);

endmodule
